// File: rtl/lcd_pattern_gen_if.sv
// Shared LCD command codes and the bus between the pattern generator and the LCD controller.
// The generator drives commands, rectangles and the pixel stream; the controller returns pixel position and readiness.
package lcd_defs_pkg;
    localparam logic [2:0] LCD_CMD_NONE       = 3'd0;
    localparam logic [2:0] LCD_CMD_CONFIGURE  = 3'd1;
    localparam logic [2:0] LCD_CMD_FILL_RECT  = 3'd2;
    localparam logic [2:0] LCD_CMD_WRITE_RECT = 3'd3;
endpackage

interface lcd_pattern_gen_if #(
    parameter int CoordinateWidth = 9,
    parameter int PixelWidth      = 16,
    parameter int CommandWidth    = 3
);
    logic                       lcd_ready;
    logic [CommandWidth-1:0]    lcd_command;
    logic [PixelWidth-1:0]      fill_pixel;
    logic [CoordinateWidth-1:0] rect_x0;
    logic [CoordinateWidth-1:0] rect_x1;
    logic [CoordinateWidth-1:0] rect_y0;
    logic [CoordinateWidth-1:0] rect_y1;
    logic [CoordinateWidth-1:0] pixel_x;
    logic [CoordinateWidth-1:0] pixel_y;
    logic [PixelWidth-1:0]      pixel_write;
    logic                       pixel_write_valid;
    logic                       pixel_write_ready;

    modport master (
        input  lcd_ready, pixel_x, pixel_y, pixel_write_ready,
        output lcd_command, fill_pixel, rect_x0, rect_x1, rect_y0, rect_y1,
               pixel_write, pixel_write_valid
    );

    modport slave (
        output lcd_ready, pixel_x, pixel_y, pixel_write_ready,
        input  lcd_command, fill_pixel, rect_x0, rect_x1, rect_y0, rect_y1,
               pixel_write, pixel_write_valid
    );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Button-driven LCD test pattern generator: issues one-cycle LCD commands from button presses
// and streams a selectable test pattern relative to the current rectangle origin.
module lcd_pattern_gen #(
    parameter int PanelWidth      = 480,
    parameter int PanelHeight     = 320,
    parameter int CoordinateWidth = 9,
    parameter int PixelWidth      = 16,
    parameter int CommandWidth    = 3,
    parameter int GridShift       = 4,
    parameter int HoldCount       = 2**20,
    parameter int ShortCount      = 10
) (
    input  logic                  clock_48mhz,
    input  logic                  reset,
    input  logic [7:0]            btn_n,
    lcd_pattern_gen_if.master     lcd,
    output logic [2:0]            mode,
    output logic                  busy
);
    import lcd_defs_pkg::*;

    localparam int HoldMax  = (HoldCount > ShortCount) ? HoldCount : ShortCount;
    localparam int CntWidth = $clog2(HoldMax + 1);

    localparam logic [CntWidth-1:0] CNT_ZERO   = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CNT_ONE    = CntWidth'(1);
    localparam logic [CntWidth-1:0] SHORT_LOAD = CntWidth'(ShortCount - 1);
    localparam logic [CntWidth-1:0] HOLD_LOAD  = CntWidth'(HoldCount - 1);

    localparam logic [CoordinateWidth-1:0] X_ZERO  = {CoordinateWidth{1'b0}};
    localparam logic [CoordinateWidth-1:0] X_LAST  = CoordinateWidth'(PanelWidth - 1);
    localparam logic [CoordinateWidth-1:0] Y_LAST  = CoordinateWidth'(PanelHeight - 1);
    localparam logic [CoordinateWidth-1:0] X_QTR   = CoordinateWidth'(PanelWidth / 4);
    localparam logic [CoordinateWidth-1:0] X_3QTR  = CoordinateWidth'(3 * PanelWidth / 4);
    localparam logic [CoordinateWidth-1:0] Y_8TH   = CoordinateWidth'(PanelHeight / 8);
    localparam logic [CoordinateWidth-1:0] Y_7_8TH = CoordinateWidth'(7 * PanelHeight / 8);
    localparam logic [CoordinateWidth-1:0] SWEEP_X = CoordinateWidth'(64);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    logic [7:0]                 btn_meta_q;
    logic [7:0]                 btn_sync_q;
    logic [7:0]                 pressed_s;
    logic                       unused_btn_s;

    state_e                     state_q,  state_d;
    logic [CntWidth-1:0]        cnt_q,    cnt_d;
    logic [CommandWidth-1:0]    cmd_q,    cmd_d;
    logic [PixelWidth-1:0]      fill_q,   fill_d;
    logic [CoordinateWidth-1:0] x0_q,     x0_d;
    logic [CoordinateWidth-1:0] x1_q,     x1_d;
    logic [CoordinateWidth-1:0] y0_q,     y0_d;
    logic [CoordinateWidth-1:0] y1_q,     y1_d;
    logic [2:0]                 mode_q,   mode_d;
    logic [6:0]                 sweep_q,  sweep_d;
    logic [7:0]                 colour_q, colour_d;
    logic                       busy_q;

    logic [CoordinateWidth-1:0] rx_s;
    logic [CoordinateWidth-1:0] ry_s;
    logic [15:0]                pattern_s;
    logic [PixelWidth-1:0]      pixel_q;
    logic                       valid_q;

    assign pressed_s    = ~btn_sync_q;
    // Buttons 4, 6 and 7 have no function; they are synchronised only to keep the bus uniform.
    assign unused_btn_s = &{1'b0, pressed_s[7:6], pressed_s[4]};

    // Two-flop synchroniser for the asynchronous push buttons
    always_ff @(posedge clock_48mhz) begin
        if (reset) begin
            btn_meta_q <= 8'hFF;
            btn_sync_q <= 8'hFF;
        end else begin
            btn_meta_q <= btn_n;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Action selection and hold countdown; lowest-numbered pressed button wins
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = CommandWidth'(LCD_CMD_NONE);
        fill_d   = fill_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        mode_d   = mode_q;
        sweep_d  = sweep_q;
        colour_d = colour_q;
        case (state_q)
            ST_IDLE: begin
                if (pressed_s[0]) begin
                    cmd_d   = CommandWidth'(LCD_CMD_CONFIGURE);
                    state_d = ST_HOLD;
                    cnt_d   = SHORT_LOAD;
                end else if (pressed_s[1]) begin
                    if (lcd.lcd_ready) begin
                        cmd_d   = CommandWidth'(LCD_CMD_FILL_RECT);
                        x0_d    = X_ZERO;
                        x1_d    = X_LAST;
                        y0_d    = X_ZERO;
                        y1_d    = Y_LAST;
                        fill_d  = {PixelWidth{1'b0}};
                        state_d = ST_HOLD;
                        cnt_d   = SHORT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (pressed_s[2]) begin
                    if (lcd.lcd_ready) begin
                        cmd_d   = CommandWidth'(LCD_CMD_WRITE_RECT);
                        x0_d    = X_QTR;
                        x1_d    = X_3QTR;
                        y0_d    = Y_8TH;
                        y1_d    = Y_7_8TH;
                        state_d = ST_HOLD;
                        cnt_d   = SHORT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (pressed_s[3]) begin
                    if (lcd.lcd_ready) begin
                        if (mode_q == 3'd4) begin
                            mode_d = 3'd0;
                        end else begin
                            mode_d = mode_q + 3'd1;
                        end
                        state_d = ST_HOLD;
                        cnt_d   = SHORT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (pressed_s[5]) begin
                    if (lcd.lcd_ready) begin
                        cmd_d   = CommandWidth'(LCD_CMD_FILL_RECT);
                        x0_d    = SWEEP_X + CoordinateWidth'(sweep_q);
                        x1_d    = SWEEP_X + CoordinateWidth'(sweep_q);
                        y0_d    = Y_8TH;
                        y1_d    = Y_7_8TH;
                        fill_d  = {{(PixelWidth-5){1'b0}}, colour_q[7:3]};
                        // Each full sweep of the column shifts the colour for the next pass.
                        if (sweep_q == 7'd127) begin
                            sweep_d  = 7'd0;
                            colour_d = colour_q + 8'd155;
                        end else begin
                            sweep_d  = sweep_q + 7'd1;
                        end
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and rectangle registers
    always_ff @(posedge clock_48mhz) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            cmd_q    <= CommandWidth'(LCD_CMD_NONE);
            fill_q   <= {PixelWidth{1'b0}};
            x0_q     <= X_ZERO;
            x1_q     <= X_ZERO;
            y0_q     <= X_ZERO;
            y1_q     <= X_ZERO;
            mode_q   <= 3'd0;
            sweep_q  <= 7'd0;
            colour_q <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            fill_q   <= fill_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            mode_q   <= mode_d;
            sweep_q  <= sweep_d;
            colour_q <= colour_d;
            busy_q   <= (state_d == ST_HOLD);
        end
    end

    // Pattern for the controller's next pixel, relative to the rectangle origin
    always_comb begin
        rx_s = lcd.pixel_x - x0_q;
        ry_s = lcd.pixel_y - y0_q;
        case (mode_q)
            3'd0: pattern_s = ((rx_s[GridShift-1:0] == {GridShift{1'b0}}) ||
                               (ry_s[GridShift-1:0] == {GridShift{1'b0}})) ? 16'hFFFF : 16'h0000;
            3'd1: pattern_s = (rx_s[GridShift] ^ ry_s[GridShift]) ? 16'hFFFF : 16'h0000;
            3'd2: pattern_s = {rx_s[7:3], rx_s[7:2], rx_s[7:3]};
            3'd3: pattern_s = {{5{rx_s[CoordinateWidth-1]}}, {6{rx_s[CoordinateWidth-2]}},
                               {5{rx_s[CoordinateWidth-3]}}};
            3'd4: pattern_s = 16'h07E0;
            default: pattern_s = 16'h0000;
        endcase
    end

    // Pixel stream register; keeps loading through reset so data is always meaningful
    always_ff @(posedge clock_48mhz) begin
        valid_q <= 1'b1;
        if (lcd.pixel_write_ready) begin
            pixel_q <= PixelWidth'(pattern_s);
        end else begin
            pixel_q <= pixel_q;
        end
    end

    assign lcd.lcd_command       = cmd_q;
    assign lcd.fill_pixel        = fill_q;
    assign lcd.rect_x0           = x0_q;
    assign lcd.rect_x1           = x1_q;
    assign lcd.rect_y0           = y0_q;
    assign lcd.rect_y1           = y1_q;
    assign lcd.pixel_write       = pixel_q;
    assign lcd.pixel_write_valid = valid_q;
    assign mode                  = mode_q;
    assign busy                  = busy_q;
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Randomised scoreboard bench for lcd_pattern_gen: a cycle-level reference model predicts every
// output after each clock edge and a separate monitor compares the DUT against the queued predictions.
module tb_lcd_pattern_gen;
    import lcd_defs_pkg::*;

    localparam int HOLD  = 4;
    localparam int SHORT = 10;

    logic       clock_48mhz = 1'b0;
    logic       reset       = 1'b1;
    logic [7:0] btn_n       = 8'hFF;
    logic [2:0] mode;
    logic       busy;

    lcd_pattern_gen_if #(.CoordinateWidth(9), .PixelWidth(16), .CommandWidth(3)) lcd_bus ();

    lcd_pattern_gen #(.HoldCount(HOLD), .ShortCount(SHORT)) dut (
        .clock_48mhz (clock_48mhz),
        .reset       (reset),
        .btn_n       (btn_n),
        .lcd         (lcd_bus),
        .mode        (mode),
        .busy        (busy)
    );

    always #5 clock_48mhz = ~clock_48mhz;

    typedef struct {
        int cmd;
        int x0, x1, y0, y1;
        int fill;
        int mode;
        int busy;
        int pix;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state (integers, updated once per clock edge)
    int   m_mode = 0, m_sweep = 0, m_colour = 0;
    int   m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0, m_fill = 0;
    int   m_remain = 0, m_pix = 0;
    logic [7:0] m_s1 = 8'hFF, m_s2 = 8'hFF;

    function automatic int pattern(input int md, input int px, input int py, input int x0, input int y0);
        int rx, ry, bar;
        rx  = (px - x0 + 512) % 512;
        ry  = (py - y0 + 512) % 512;
        bar = rx / 64;
        case (md)
            0: return ((rx % 16 == 0) || (ry % 16 == 0)) ? 32'hFFFF : 0;
            1: return ((((rx / 16) + (ry / 16)) % 2) == 1) ? 32'hFFFF : 0;
            2: return ((rx % 256) / 8) * 2048 + ((rx % 256) / 4) * 32 + (rx % 256) / 8;
            3: return ((bar / 4) * 31 * 2048) + (((bar / 2) % 2) * 63 * 32) + ((bar % 2) * 31);
            4: return 32'h07E0;
            default: return 0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic [7:0] b, input logic rdy,
                        input int px, input int py, input logic pwr);
        exp_t       e;
        int         act;
        logic [7:0] pr;
        e.cmd = int'(LCD_CMD_NONE);
        if (pwr) m_pix = pattern(m_mode, px, py, m_x0, m_y0);
        if (rst) begin
            m_mode = 0; m_sweep = 0; m_colour = 0;
            m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_fill = 0;
            m_remain = 0; m_s1 = 8'hFF; m_s2 = 8'hFF;
        end else begin
            pr = ~m_s2;
            if (m_remain > 0) begin
                m_remain--;
            end else begin
                act = -1;
                for (int i = 0; i < 8; i++)
                    if (act < 0 && pr[i] && (i <= 3 || i == 5)) act = i;
                if (act == 0) begin
                    e.cmd = int'(LCD_CMD_CONFIGURE); m_remain = SHORT;
                end else if (act > 0 && rdy) begin
                    case (act)
                        1: begin
                            e.cmd = int'(LCD_CMD_FILL_RECT);
                            m_x0 = 0; m_x1 = 479; m_y0 = 0; m_y1 = 319; m_fill = 0; m_remain = SHORT;
                        end
                        2: begin
                            e.cmd = int'(LCD_CMD_WRITE_RECT);
                            m_x0 = 120; m_x1 = 360; m_y0 = 40; m_y1 = 280; m_remain = SHORT;
                        end
                        3: begin
                            m_mode = (m_mode + 1) % 5; m_remain = SHORT;
                        end
                        default: begin
                            e.cmd = int'(LCD_CMD_FILL_RECT);
                            m_x0 = 64 + m_sweep; m_x1 = 64 + m_sweep; m_y0 = 40; m_y1 = 280;
                            m_fill = m_colour / 8;
                            if (m_sweep == 127) begin
                                m_sweep = 0; m_colour = (m_colour + 155) % 256;
                            end else begin
                                m_sweep++;
                            end
                            m_remain = HOLD;
                        end
                    endcase
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        e.x0 = m_x0; e.x1 = m_x1; e.y0 = m_y0; e.y1 = m_y1; e.fill = m_fill;
        e.mode = m_mode; e.busy = (m_remain > 0) ? 1 : 0; e.pix = m_pix;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive_full(input logic rst, input logic [7:0] b, input logic rdy,
                              input int px, input int py, input logic pwr);
        @(negedge clock_48mhz);
        reset                     = rst;
        btn_n                     = b;
        lcd_bus.lcd_ready         = rdy;
        lcd_bus.pixel_x           = px[8:0];
        lcd_bus.pixel_y           = py[8:0];
        lcd_bus.pixel_write_ready = pwr;
        step(rst, b, rdy, px, py, pwr);
    endtask

    task automatic drive(input logic rst, input logic [7:0] b, input logic rdy);
        drive_full(rst, b, rdy, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 3) != 0);
    endtask

    // Monitor: pops one prediction per clock edge and compares every output
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_48mhz);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("lcd_command", 32'(lcd_bus.lcd_command), e.cmd);
                check("rect_x0", 32'(lcd_bus.rect_x0), e.x0);
                check("rect_x1", 32'(lcd_bus.rect_x1), e.x1);
                check("rect_y0", 32'(lcd_bus.rect_y0), e.y0);
                check("rect_y1", 32'(lcd_bus.rect_y1), e.y1);
                check("fill_pixel", 32'(lcd_bus.fill_pixel), e.fill);
                check("mode", 32'(mode), e.mode);
                check("busy", 32'(busy), e.busy);
                check("pixel_write", 32'(lcd_bus.pixel_write), e.pix);
                check("pixel_write_valid", 32'(lcd_bus.pixel_write_valid), 32'd1);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomised button segments
    initial begin
        logic [7:0] b;
        int         len;
        int         sel;
        lcd_bus.lcd_ready         = 1'b0;
        lcd_bus.pixel_x           = 9'd0;
        lcd_bus.pixel_y           = 9'd0;
        lcd_bus.pixel_write_ready = 1'b1;

        for (int i = 0; i < 4; i++) drive_full(1'b1, 8'hFF, 1'b0, $urandom_range(0, 511), $urandom_range(0, 511), 1'b1);

        for (int i = 0; i < 30; i++) drive(1'b0, 8'hFE, 1'b0);
        for (int i = 0; i < 15; i++) drive(1'b0, 8'hFF, 1'b0);

        for (int i = 0; i < 5; i++)  drive(1'b0, 8'hF9, 1'b1);
        for (int i = 0; i < 15; i++) drive(1'b0, 8'hFF, 1'b1);

        for (int i = 0; i < 3; i++)  drive(1'b0, 8'hFB, 1'b1);
        for (int i = 0; i < 15; i++) drive(1'b0, 8'hFF, 1'b1);

        drive_full(1'b0, 8'hFF, 1'b1, 136, 41, 1'b1);
        drive_full(1'b0, 8'hFF, 1'b1, 137, 41, 1'b1);
        drive_full(1'b0, 8'hFF, 1'b1, 136, 40, 1'b0);

        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 3; i++)  drive(1'b0, 8'hF7, 1'b1);
            for (int i = 0; i < 40; i++) drive(1'b0, 8'hFF, 1'b1);
        end

        for (int i = 0; i < 660; i++) drive(1'b0, 8'hDF, 1'b1);
        for (int i = 0; i < 10; i++)  drive(1'b0, 8'hFF, 1'b1);

        for (int i = 0; i < 3; i++) drive(1'b0, 8'hFD, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'hFF, 1'b1);
        drive(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 8'hFF, 1'b1);

        for (int s = 0; s < 80; s++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: b = 8'hFF;
                1, 2: b = ~(8'd1 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) drive(1'b1, 8'hFF, 1'b1);
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) drive(1'b0, b, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 3; i++) drive(1'b0, 8'hFF, 1'b1);
        @(posedge clock_48mhz);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
